// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_pkg
//  Description : Shared types and constants for the fetch stage and its
//                fetch/decode pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // Bit positions inside the exception vector carried down the pipe
    localparam int EXC_IADDR_MISALIGNED = 0;
    localparam int EXC_IACCESS_FAULT    = 1;

    // Only the low cause bits are ever set by fetch; the rest of the
    // exception vector is zero-extended at the stage boundary.
    localparam int EXC_CAUSE_W = 2;

    // addi x0, x0, 0 - substituted for the instruction word on any fetch fault
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [63:0]            pc;
        logic [31:0]            instr;
        logic [EXC_CAUSE_W-1:0] exc;
    } fetch_entry_t;

    // One-hot cause vector with a single bit set at position idx
    function automatic logic [EXC_CAUSE_W-1:0] exc_cause(input int idx);
        logic [EXC_CAUSE_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Front-end fetch stage. Owns the PC, issues one instruction
//                memory request at a time, and delivers (pc, instr, exception)
//                to the fetch/decode register through a one-entry output slot
//                backed by a one-entry skid buffer. Handles redirects and
//                discards responses that belong to a flushed request.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          EXC_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic              imem_req_valid,
    output logic [63:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              imem_resp_err,
    output logic              fetch_valid,
    output logic [63:0]       pc_from_fetch,
    output logic [31:0]       instr_from_fetch,
    output logic [EXC_W-1:0]  exception_from_fetch
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fetch_state_t r_state;
    logic [63:0]  r_pc;
    fetch_entry_t r_slot;
    logic         r_slot_valid;
    fetch_entry_t r_skid;
    logic         r_skid_valid;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic         w_pc_aligned;
    logic         w_slot_free;
    logic         w_req_valid;
    logic         w_req_fire;
    logic         w_resp_take;
    logic         w_fault_take;
    logic         w_new_valid;
    fetch_entry_t w_resp_entry;
    fetch_entry_t w_fault_entry;
    fetch_entry_t w_new_entry;

    assign w_pc_aligned = (r_pc[1:0] == 2'b00);

    // The slot can accept an entry when it is empty or being consumed now
    assign w_slot_free  = !r_slot_valid || !stall;

    // Requests are held off while in reset, while a redirect is flushing the
    // front end, and while the skid still owes an entry to the slot.
    assign w_req_valid  = rst && (r_state == FETCH) && w_pc_aligned &&
                          !r_skid_valid && !redirect_valid;
    assign w_req_fire   = w_req_valid && imem_req_ready;

    // Responses only count while a live request is outstanding
    assign w_resp_take  = (r_state == WAIT) && imem_resp_valid;

    // A misaligned PC produces a synthetic faulting entry instead of a
    // request; it waits for the slot (and for any skid entry ahead of it).
    assign w_fault_take = (r_state == FETCH) && !w_pc_aligned &&
                          w_slot_free && !r_skid_valid;

    // Build the entry for an arriving response; faulted fetches carry a NOP
    always_comb begin
        w_resp_entry.pc    = r_pc;
        w_resp_entry.instr = imem_resp_err ? NOP_INSTR : imem_resp_data;
        w_resp_entry.exc   = imem_resp_err ? exc_cause(EXC_IACCESS_FAULT) : '0;
    end

    // Build the entry reported for a misaligned fetch target
    always_comb begin
        w_fault_entry.pc    = r_pc;
        w_fault_entry.instr = NOP_INSTR;
        w_fault_entry.exc   = exc_cause(EXC_IADDR_MISALIGNED);
    end

    assign w_new_valid = w_resp_take || w_fault_take;
    assign w_new_entry = w_resp_take ? w_resp_entry : w_fault_entry;

    // ------------------------------------------------------------------
    // Fetch FSM and program counter; redirect overrides everything else
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
            // An in-flight request whose response has not yet shown up must
            // have that response swallowed before fetching resumes.
            if ((r_state == WAIT) && !imem_resp_valid) begin
                r_state <= DRAIN;
            end else begin
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_req_fire) begin
                        r_state <= WAIT;
                    end else if (w_fault_take) begin
                        r_state <= FAULT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (imem_resp_err) begin
                            r_state <= FAULT;
                        end else begin
                            r_pc    <= r_pc + 64'd4;
                            r_state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_resp_valid) begin
                        r_state <= FETCH;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output slot and skid buffer; skid drains ahead of any new entry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot       <= '0;
            r_slot_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_slot_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_slot_free) begin
            if (r_skid_valid) begin
                r_slot       <= r_skid;
                r_slot_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_new_valid) begin
                r_slot       <= w_new_entry;
                r_slot_valid <= 1'b1;
            end else begin
                r_slot_valid <= 1'b0;
            end
        end else if (w_resp_take) begin
            // Slot is full and stalled: park the response. The skid is
            // guaranteed empty here because a full skid blocks new requests.
            r_skid       <= w_resp_entry;
            r_skid_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid   = w_req_valid;
    assign imem_req_addr    = r_pc;
    assign fetch_valid      = r_slot_valid;
    assign pc_from_fetch    = r_slot.pc;
    assign instr_from_fetch = r_slot.instr;

    generate
        if (EXC_W > EXC_CAUSE_W) begin : g_exc_wide
            assign exception_from_fetch = {{(EXC_W-EXC_CAUSE_W){1'b0}}, r_slot.exc};
        end else begin : g_exc_narrow
            assign exception_from_fetch = r_slot.exc[EXC_W-1:0];
        end
    endgenerate

endmodule : instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end fetch stage. Owns the program counter and issues one instruction-memory request at a time.
- Delivers (pc, instr, exception) to the fetch/decode pipeline register with a valid/stall handshake.
- Handles redirects from branch resolution and traps, and drops responses that have gone stale.
- Sits directly upstream of the fetch/decode register; its outputs drive that register's *_from_fetch inputs.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- EXC_W, 16, width of the exception vector passed down the pipe.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- stall  in  1  downstream not accepting this cycle; the fetch/decode register enable is the complement of stall
- redirect_valid  in  1  flush the front end and restart at redirect_pc
- redirect_pc  in  64  new fetch target
- imem_req_valid  out  1  request valid
- imem_req_addr  out  64  request address (current pc)
- imem_req_ready  in  1  memory accepts the request
- imem_resp_valid  in  1  response valid; cannot be back-pressured
- imem_resp_data  in  32  instruction word
- imem_resp_err  in  1  access fault on this fetch
- fetch_valid  out  1  output slot holds a valid instruction
- pc_from_fetch  out  64  pc of the slot
- instr_from_fetch  out  32  instruction of the slot
- exception_from_fetch  out  EXC_W  exception vector of the slot

Behaviour:
- Reset (rst==0 at posedge) sets:
  - pc=RESET_PC, state=FETCH, skid empty.
  - fetch_valid=0, and pc/instr/exception outputs=0.
  - imem_req_valid=0 during the reset cycle.
- Any response arriving while in FETCH or FAULT is ignored. The memory side shares rst.
- States:
  - FETCH: imem_req_valid=1 and imem_req_addr=pc when pc[1:0]==0, the skid is empty, and redirect_valid==0.
    - On valid&&ready: go to WAIT.
    - If pc[1:0]!=0: issue no request. Load the slot when it is free with instr=32'h0000_0013, exception bit0=1, pc=pc. Go to FAULT.
  - WAIT: on imem_resp_valid, the entry is {pc, data, err?bit1:0}. On err, instr=32'h0000_0013.
    - Slot free (!fetch_valid || !stall): entry goes to the slot. Otherwise it goes to the 1-entry skid.
    - err=0: pc<=pc+4 (mod 2^64), go to FETCH.
    - err=1: pc unchanged, go to FAULT.
  - DRAIN: discard the next imem_resp_valid, then go to FETCH.
  - FAULT: no requests. Wait for redirect_valid.
- Output slot:
  - Consumed when fetch_valid && !stall.
  - Loaded (registered, visible next cycle) when free and a new entry exists. The skid has priority over a new response.
  - If nothing loads, fetch_valid<=0 on consumption.
  - Stalled slot contents are held stable.
- Skid:
  - Filled only when a response arrives with the slot full and stalled.
  - Drains into the slot on the first non-stall cycle.
  - While the skid is full, no new request is issued.
- Redirect (highest priority, overrides stall):
  - pc<=redirect_pc, fetch_valid<=0, skid cleared, imem_req_valid=0 that cycle.
  - Next state is DRAIN when in WAIT and no response arrives in that cycle. Otherwise (including a same-cycle response, which is dropped) next state is FETCH.
  - A misaligned redirect_pc faults on the next FETCH.
- Exception vector: bit0 = instruction address misaligned, bit1 = instruction access fault, all other bits 0.
- Latency: request accepted at cycle N, response at M ≥ N+1, fetch_valid high at M+1 when not stalled.
- Throughput: 1 instruction per 2 cycles with a single-cycle memory.

Decomposition:
- Shared package (pipeline pkg):
  - EXC_IADDR_MISALIGNED=0 and EXC_IACCESS_FAULT=1 bit indices
  - NOP_INSTR=32'h0000_0013
  - fetch_state_t enum {FETCH, WAIT, DRAIN, FAULT}
  - fetch_entry_t struct {pc, instr, exc}
- No sub-module. The slot and skid are two fetch_entry_t registers plus valid bits.

Test Plan:
1. Release rst, memory ready and 1-cycle latency returning 32'h00500093 → request addr 0x80000000; fetch_valid with pc 0x80000000; next request 0x80000004.
2. Hold stall=1 for 5 cycles while two responses are pending → slot holds 0x80000000, skid holds 0x80000004, no third request; deassert stall → 0x80000004 appears the following cycle and no entry is lost.
3. redirect_valid with redirect_pc=0x80001000 while in WAIT, then a stale response → stale response dropped; next request addr 0x80001000; fetch_valid stays 0 until the fresh response arrives.
4. Redirect and response in the same cycle, with stall=1 → response dropped, slot cleared, request to the new pc issued the next cycle.
5. redirect_pc=0x80000002 → no imem request; slot gets pc 0x80000002, instr 0x00000013, exception 16'h0001; stays in FAULT until the next redirect.
6. Response with imem_resp_err=1 at 0x80000008 → exception 16'h0002, instr NOP, pc not incremented, no further requests; rst low mid-WAIT → outputs reset to 0 and the late response is ignored.
